// File: rtl/timer_bank.sv
// Bank of NUM_TIMERS prescaled down-counters with one-shot/auto-reload modes and a
// shared pending/mask interrupt unit on a byte-wide register bus (registered reads).
module timer_bank #(
  parameter int NUM_TIMERS = 2,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  output logic                  irq,
  output logic [NUM_TIMERS-1:0] irq_vec
);

  localparam logic [ADDR_W-1:0] PEND_A = ADDR_W'(4 * NUM_TIMERS);
  localparam logic [ADDR_W-1:0] MASK_A = ADDR_W'(4 * NUM_TIMERS + 1);

  logic [NUM_TIMERS-1:0] r_en;
  logic [NUM_TIMERS-1:0] r_auto;
  logic [DATA_W-1:0]     r_reload [NUM_TIMERS];
  logic [DATA_W-1:0]     r_count  [NUM_TIMERS];
  logic [DATA_W-1:0]     r_presc  [NUM_TIMERS];
  logic [DATA_W-1:0]     r_pcnt   [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] r_pending;
  logic [NUM_TIMERS-1:0] r_mask;
  logic [DATA_W-1:0]     r_dout;

  logic                  w_wr;
  logic                  w_rd;
  logic                  w_wr_pend;
  logic                  w_wr_mask;
  logic [NUM_TIMERS-1:0] w_wr_ctrl;
  logic [NUM_TIMERS-1:0] w_wr_rel;
  logic [NUM_TIMERS-1:0] w_wr_cnt;
  logic [NUM_TIMERS-1:0] w_wr_psc;
  logic [NUM_TIMERS-1:0] w_restart;
  logic [NUM_TIMERS-1:0] w_tick;
  logic [NUM_TIMERS-1:0] w_expire;
  logic [NUM_TIMERS-1:0] w_din_n;
  logic [NUM_TIMERS-1:0] w_w1c;
  logic [DATA_W-1:0]     w_rdata;

  assign w_wr      = cs & we;
  assign w_rd      = cs & ~we;
  assign w_wr_pend = w_wr && (addr == PEND_A);
  assign w_wr_mask = w_wr && (addr == MASK_A);
  assign w_din_n   = NUM_TIMERS'(din);
  assign w_w1c     = w_wr_pend ? w_din_n : '0;

  // A COUNT write suppresses both the decrement and the expiry of that channel on that edge
  always_comb begin
    w_wr_ctrl = '0;
    w_wr_rel  = '0;
    w_wr_cnt  = '0;
    w_wr_psc  = '0;
    w_restart = '0;
    w_tick    = '0;
    w_expire  = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      w_wr_ctrl[i] = w_wr && (addr == ADDR_W'(4 * i));
      w_wr_rel[i]  = w_wr && (addr == ADDR_W'(4 * i + 1));
      w_wr_cnt[i]  = w_wr && (addr == ADDR_W'(4 * i + 2));
      w_wr_psc[i]  = w_wr && (addr == ADDR_W'(4 * i + 3));
      w_restart[i] = w_wr_ctrl[i] && din[2];
      w_tick[i]    = r_en[i] && (r_pcnt[i] == r_presc[i]);
      w_expire[i]  = w_tick[i] && (r_count[i] == '0) && !w_wr_cnt[i];
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (addr == ADDR_W'(4 * i))     w_rdata = DATA_W'({r_auto[i], r_en[i]});
      if (addr == ADDR_W'(4 * i + 1)) w_rdata = r_reload[i];
      if (addr == ADDR_W'(4 * i + 2)) w_rdata = r_count[i];
      if (addr == ADDR_W'(4 * i + 3)) w_rdata = r_presc[i];
    end
    if (addr == PEND_A) w_rdata = DATA_W'(r_pending);
    if (addr == MASK_A) w_rdata = DATA_W'(r_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en      <= '0;
      r_auto    <= '0;
      r_pending <= '0;
      r_mask    <= '0;
      r_dout    <= '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        r_reload[i] <= '0;
        r_count[i]  <= '0;
        r_presc[i]  <= '0;
        r_pcnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        // A bus write to CTRL overrides the one-shot self-disable
        if (w_wr_ctrl[i]) begin
          r_en[i]   <= din[0];
          r_auto[i] <= din[1];
        end else if (w_expire[i] && !r_auto[i]) begin
          r_en[i] <= 1'b0;
        end
        if (w_wr_rel[i]) r_reload[i] <= din;
        if (w_wr_psc[i]) r_presc[i]  <= din;

        if (w_restart[i])   r_pcnt[i] <= '0;
        else if (w_tick[i]) r_pcnt[i] <= '0;
        else if (r_en[i])   r_pcnt[i] <= r_pcnt[i] + DATA_W'(1);

        if (w_wr_cnt[i]) begin
          r_count[i] <= din;
        end else if (w_restart[i]) begin
          r_count[i] <= r_reload[i];
        end else if (w_tick[i]) begin
          if (r_count[i] != '0) r_count[i] <= r_count[i] - DATA_W'(1);
          else if (r_auto[i])   r_count[i] <= r_reload[i];
        end
      end
      // Set-on-expiry takes priority over write-1-to-clear
      r_pending <= (r_pending & ~w_w1c) | w_expire;
      if (w_wr_mask) r_mask <= w_din_n;
      if (w_rd)      r_dout <= w_rdata;
    end
  end

  assign dout    = r_dout;
  assign irq_vec = r_pending & r_mask;
  assign irq     = |irq_vec;

endmodule

// File: tb/tb_timer_bank.sv
// Randomised and directed bench for timer_bank against a cycle-level behavioural model.
module tb_timer_bank;
  localparam int NT = 2;
  localparam int DW = 8;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cs  = 1'b0;
  logic          we  = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din  = '0;
  logic [DW-1:0] dout;
  logic          irq;
  logic [NT-1:0] irq_vec;

  timer_bank #(.NUM_TIMERS(NT), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din),
    .dout(dout), .irq(irq), .irq_vec(irq_vec)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int edge_no = 0;

  // behavioural model state
  int m_en[NT], m_auto[NT], m_rel[NT], m_cnt[NT], m_psc[NT], m_pc[NT];
  int m_pend = 0, m_mask = 0, m_dout = 0;

  function automatic int mread(int a);
    if (a < 4 * NT) begin
      case (a % 4)
        0: return m_en[a / 4] | (m_auto[a / 4] << 1);
        1: return m_rel[a / 4];
        2: return m_cnt[a / 4];
        default: return m_psc[a / 4];
      endcase
    end
    if (a == 4 * NT)     return m_pend;
    if (a == 4 * NT + 1) return m_mask;
    return 0;
  endfunction

  task automatic model_step(input bit r, input bit c, input bit w, input int a, input int d);
    int all, exp_bits, w1c;
    all = (1 << NT) - 1;
    if (r) begin
      for (int i = 0; i < NT; i++) begin
        m_en[i] = 0; m_auto[i] = 0; m_rel[i] = 0; m_cnt[i] = 0; m_psc[i] = 0; m_pc[i] = 0;
      end
      m_pend = 0; m_mask = 0; m_dout = 0;
      return;
    end
    if (c && !w) m_dout = mread(a);
    exp_bits = 0;
    for (int i = 0; i < NT; i++) begin
      bit tick, wctl, wcnt, restart, expire;
      tick    = (m_en[i] != 0) && (m_pc[i] == m_psc[i]);
      wctl    = c && w && (a == 4 * i);
      wcnt    = c && w && (a == 4 * i + 2);
      restart = wctl && ((d >> 2) & 1);
      expire  = tick && (m_cnt[i] == 0) && !wcnt;
      if (expire) exp_bits |= (1 << i);
      if (restart)       m_pc[i] = 0;
      else if (m_en[i] != 0) m_pc[i] = tick ? 0 : (m_pc[i] + 1) % 256;
      if (wcnt)          m_cnt[i] = d;
      else if (restart)  m_cnt[i] = m_rel[i];
      else if (tick)     m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : (m_auto[i] ? m_rel[i] : 0);
      if (wctl) begin
        m_en[i] = d & 1; m_auto[i] = (d >> 1) & 1;
      end else if (expire && !m_auto[i]) begin
        m_en[i] = 0;
      end
      if (c && w && a == 4 * i + 1) m_rel[i] = d;
      if (c && w && a == 4 * i + 3) m_psc[i] = d;
    end
    w1c = (c && w && a == 4 * NT) ? (d & all) : 0;
    m_pend = (m_pend & ~w1c) | exp_bits;
    if (c && w && a == 4 * NT + 1) m_mask = d & all;
  endtask

  task automatic cyc(input bit r, input bit c, input bit w, input int a, input int d);
    rst  = r;
    cs   = c;
    we   = w;
    addr = AW'(a);
    din  = DW'(d);
    model_step(r, c, w, a, d & 8'hFF);
    @(posedge clk);
    #1;
    edge_no++;
    rst = 1'b0; cs = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input int a, input int d); cyc(0, 1, 1, a, d); endtask
  task automatic rd(input int a);              cyc(0, 1, 0, a, 0); endtask
  task automatic idle();                       cyc(0, 0, 0, 0, 0); endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    vecs++;
    if (irq !== 1'b0 || irq_vec !== '0) begin
      errs++; $display("FAIL reset_irq got irq=%0b vec=%0h want 0/0", irq, irq_vec);
    end
    for (int a = 0; a < 64; a++) begin
      rd(a);
      vecs++;
      if (dout !== 8'h00) begin
        errs++; $display("FAIL reset_read a=%0d got %0h want 00", a, dout);
      end
    end
  endtask

  task automatic test_auto_reload();
    int prev, found;
    wr(1, 3); wr(3, 0); wr(9, 1); wr(0, 8'h07);
    prev = edge_no;
    for (int k = 0; k < 4; k++) begin
      found = 0;
      for (int t = 0; t < 10 && !found; t++) begin
        idle();
        if (irq === 1'b1) found = 1;
      end
      vecs++;
      if (!found) begin
        errs++; $display("FAIL auto_timeout k=%0d got no irq want irq", k);
      end else if (edge_no - prev != 4) begin
        errs++; $display("FAIL auto_period k=%0d got %0d want 4", k, edge_no - prev);
      end
      vecs++;
      if (irq_vec !== 2'b01) begin
        errs++; $display("FAIL auto_vec got %0h want 1", irq_vec);
      end
      prev = edge_no;
      wr(8, 1);
      vecs++;
      if (irq !== 1'b0) begin
        errs++; $display("FAIL auto_w1c got irq=%0b want 0", irq);
      end
    end
    wr(0, 0); wr(8, 3);
    rd(8);
    vecs++;
    if (dout !== 8'h00 || m_dout != 0) begin
      errs++; $display("FAIL auto_pend_clear got %0h want 00", dout);
    end
  endtask

  task automatic test_oneshot();
    int start, found;
    wr(9, 2); wr(5, 2); wr(7, 4); wr(4, 8'h05);
    start = edge_no;
    found = 0;
    for (int t = 0; t < 30 && !found; t++) begin
      idle();
      if (irq === 1'b1) found = 1;
    end
    vecs++;
    if (!found || edge_no - start != 15) begin
      errs++; $display("FAIL oneshot_delay got %0d want 15 (found=%0d)", edge_no - start, found);
    end
    vecs++;
    if (irq_vec !== 2'b10) begin
      errs++; $display("FAIL oneshot_vec got %0h want 2", irq_vec);
    end
    rd(4);
    vecs++;
    if (dout !== 8'h00) begin
      errs++; $display("FAIL oneshot_ctrl got %0h want 00", dout);
    end
    rd(6);
    vecs++;
    if (dout !== 8'h00) begin
      errs++; $display("FAIL oneshot_count got %0h want 00", dout);
    end
    wr(8, 2);
    found = 0;
    for (int t = 0; t < 100; t++) begin
      idle();
      if (irq !== 1'b0) found = 1;
    end
    vecs++;
    if (found) begin
      errs++; $display("FAIL oneshot_rearm got irq within 100 cycles want none");
    end
    rd(8);
    vecs++;
    if (dout !== 8'h00) begin
      errs++; $display("FAIL oneshot_pend got %0h want 00", dout);
    end
  endtask

  task automatic test_masking();
    wr(8, 3); wr(9, 2);
    wr(1, 1); wr(3, 0); wr(0, 8'h05);
    wr(5, 1); wr(7, 0); wr(4, 8'h05);
    for (int t = 0; t < 10; t++) idle();
    rd(8);
    vecs++;
    if (dout !== 8'h03) begin
      errs++; $display("FAIL mask_pend got %0h want 03", dout);
    end
    vecs++;
    if (irq_vec !== 2'b10 || irq !== 1'b1) begin
      errs++; $display("FAIL mask_irq got vec=%0h irq=%0b want 2/1", irq_vec, irq);
    end
    wr(9, 0);
    vecs++;
    if (irq !== 1'b0 || irq_vec !== 2'b00) begin
      errs++; $display("FAIL mask_off got vec=%0h irq=%0b want 0/0", irq_vec, irq);
    end
    rd(8);
    vecs++;
    if (dout !== 8'h03) begin
      errs++; $display("FAIL mask_pend_kept got %0h want 03", dout);
    end
  endtask

  task automatic test_collision();
    wr(8, 3); wr(1, 3); wr(3, 0); wr(9, 1); wr(0, 8'h07);
    idle(); idle(); idle();
    wr(8, 1);
    vecs++;
    if (irq !== 1'b1) begin
      errs++; $display("FAIL coll_w1c_irq got %0b want 1", irq);
    end
    rd(8);
    vecs++;
    if (dout[0] !== 1'b1) begin
      errs++; $display("FAIL coll_w1c_pend got %0h want bit0=1", dout);
    end
    wr(2, 9);
    rd(2);
    vecs++;
    if (dout !== 8'h09) begin
      errs++; $display("FAIL coll_count got %0h want 09", dout);
    end
    wr(0, 0); wr(8, 3);
  endtask

  task automatic test_read_latency();
    wr(1, 8'hA5);
    rd(1);
    vecs++;
    if (dout !== 8'hA5) begin
      errs++; $display("FAIL lat_read got %0h want a5", dout);
    end
    idle();
    vecs++;
    if (dout !== 8'hA5) begin
      errs++; $display("FAIL lat_hold got %0h want a5", dout);
    end
    rd(10);
    vecs++;
    if (dout !== 8'h00) begin
      errs++; $display("FAIL lat_unmapped10 got %0h want 00", dout);
    end
    wr(63, 8'hFF);
    rd(63);
    vecs++;
    if (dout !== 8'h00) begin
      errs++; $display("FAIL lat_unmapped63 got %0h want 00", dout);
    end
  endtask

  task automatic test_random();
    logic [NT-1:0] exp_v;
    for (int n = 0; n < 800; n++) begin
      int r, a, d;
      bit c, w;
      r = $urandom_range(0, 199);
      c = (r < 110);
      w = $urandom_range(0, 1);
      a = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 9);
      d = $urandom_range(0, 255);
      if (a < 8 && (a % 4 == 1 || a % 4 == 3)) d = $urandom_range(0, 5);
      if (a < 8 && a % 4 == 2) d = $urandom_range(0, 6);
      cyc(r == 199, c, w, a, d);
      exp_v = NT'(m_pend & m_mask);
      vecs++;
      if (dout !== DW'(m_dout)) begin
        errs++; $display("FAIL rand_dout n=%0d got %0h want %0h", n, dout, m_dout);
      end
      vecs++;
      if (irq_vec !== exp_v || irq !== (|exp_v)) begin
        errs++; $display("FAIL rand_irq n=%0d got vec=%0h irq=%0b want %0h/%0b", n, irq_vec, irq, exp_v, |exp_v);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_auto_reload();
    test_oneshot();
    test_masking();
    test_collision();
    test_read_latency();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/timer_bank.md
# timer_bank

Parametrised bank of NUM_TIMERS down-counting timers with per-channel prescaler, one-shot/auto-reload modes and a shared interrupt pending/mask unit, accessed over the CPU's byte-wide memory-mapped bus. Replaces the fixed pair of single timers in the top level. The top decodes a base address, drives `cs`, and routes `irq` to the CPU interrupt request logic. Read data is registered with one cycle of latency, the same as RAM.

## Interface
- NUM_TIMERS, 2, number of timer channels (1..15)
- DATA_W, 8, bus width and counter/reload/prescale width
- ADDR_W, 6, register offset width; requires 4*NUM_TIMERS+2 <= 2^ADDR_W
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cs  in  1  block selected this cycle
- we  in  1  write strobe, qualified by cs
- addr  in  ADDR_W  register offset
- din  in  DATA_W  write data
- dout  out  DATA_W  registered read data
- irq  out  1  OR of (PENDING & MASK)
- irq_vec  out  NUM_TIMERS  PENDING & MASK, one bit per channel

## Operation
- Per-channel register map (i = channel): 4i+0 CTRL, 4i+1 RELOAD, 4i+2 COUNT, 4i+3 PRESCALE. Global registers: 4N+0 PENDING, 4N+1 MASK.
- CTRL bits:
  - [0] EN
  - [1] AUTO: 1 = auto-reload, 0 = one-shot
  - [2] RESTART: write-only strobe, reads 0
  - Other bits read 0.
- Writing CTRL with RESTART=1 loads COUNT<=RELOAD and clears the prescaler. EN and AUTO are taken from din in the same write.
- Writing COUNT loads it directly. The prescaler is not affected.
- Prescaler: an internal counter per channel that runs only while EN=1. When it equals PRESCALE, it returns to 0 and produces a tick. Otherwise it increments. PRESCALE=0 gives a tick every cycle.
- On a tick:
  - COUNT != 0: COUNT <= COUNT-1.
  - COUNT == 0: the channel expires. PENDING[i] <= 1. If AUTO=1, COUNT <= RELOAD. If AUTO=0, EN <= 0 and COUNT stays 0.
- Auto-reload period is (RELOAD+1)*(PRESCALE+1) cycles. RELOAD=0 with PRESCALE=0 expires every cycle.
- PENDING is write-1-to-clear. Bits written with 0 are unchanged.
- MASK is plain read/write. Bits at or above NUM_TIMERS read 0.
- Unmapped offsets read 0. Writes to them are ignored.
- Reads have no side effects.

## Timing
- Reset: every CTRL, RELOAD, COUNT, PRESCALE, prescaler counter, PENDING and MASK = 0. dout=0, irq=0, irq_vec=0.
- Reads:
  - dout <= register value at the edge where cs=1 and we=0. Valid the cycle after addr is presented.
  - The value returned is the pre-edge register contents.
  - dout holds its value when cs=0.
- Writes take effect at the edge where cs=we=1. A write-then-read to the same register returns the new value.
- Expiry at edge E makes PENDING[i]=1 after E, so irq/irq_vec are high in the cycle following E. irq/irq_vec are combinational from the PENDING and MASK flops.
- Simultaneous events:
  - W1C of PENDING[i] on the same edge as channel i expiring: set wins, bit stays 1.
  - CTRL write on the same edge as a one-shot expiry clearing EN: the written EN wins. PENDING is still set.
  - COUNT write on the same edge as a tick: the written value wins. No decrement or expiry is evaluated that edge.
  - PRESCALE write while running: the new value is used in the next comparison. If the prescaler is already above the new value, it continues to wrap at 2^DATA_W.
- rst asserted mid-count overrides all bus and tick activity on that edge.

## Test plan
- Reset check: rst for 2 cycles, then read all offsets -> every dout=0; irq=0.
- Auto-reload: ch0 RELOAD=3, PRESCALE=0, MASK=1, CTRL=0x07 -> PENDING[0] rises after 4 cycles and every 4 cycles thereafter; irq follows one cycle after each expiry edge; W1C 0x01 clears it between expiries.
- Prescale plus one-shot: ch1 RELOAD=2, PRESCALE=4, CTRL=0x05 -> expiry after 15 cycles; CTRL reads 0x00 afterwards; COUNT stays 0; no further expiry over 100 cycles.
- Masking: both channels expire with MASK=0x02 -> PENDING=0x03, irq_vec=0x2, irq=1; write MASK=0 -> irq=0 next cycle while PENDING stays 0x03.
- Collision: W1C of PENDING[0] issued on the exact expiry edge -> PENDING[0] stays 1; COUNT write of 9 coincident with a tick -> next read returns 9.
- Read latency: write RELOAD=0xA5, then read -> dout=0xA5 exactly one cycle after addr; an unmapped offset reads 0x00.
